// File: rtl/hwpe_buffer_mp.sv
// -----------------------------------------------------------------------------
// hwpe_buffer_mp
//
// Flip-flop word buffer with one byte-maskable write port and NumRdPorts
// independent read channels. Every channel is served every cycle. There is no
// arbitration and there are no stalls.
//
// A read request registers its address. The response word is a
// combinational lookup of that held address, so read latency is one cycle.
// Because the lookup uses the current storage contents, a same-cycle write to
// the requested address is returned (write-first). A later write to a held
// address also shows up on rd_data_o in the cycle after that write.
//
// Addresses at or above NumWords are out of range. Writes to them are
// dropped, and reads of them return zero with a normal valid pulse.
//
// Optional feature (compile-time macro):
//   HWPE_BUFFER_MP_BE_EN  - defined: wr_be_i gates individual bytes of a write.
//                           undefined: wr_be_i is ignored and every write
//                           updates the full word.
//
// Ports:
//   clk_i       in   1                      clock
//   rst_ni      in   1                      asynchronous active-low reset
//   clear_i     in   1                      synchronous clear of storage and
//                                           read state (wins over wr/rd)
//   wr_req_i    in   1                      write request
//   wr_addr_i   in   AddrWidth              write word address
//   wr_data_i   in   DataWidth              write data
//   wr_be_i     in   NumBytes               write byte enables
//   rd_req_i    in   NumRdPorts             per-channel read request
//   rd_addr_i   in   NumRdPorts x AddrWidth per-channel read address
//   rd_data_o   out  NumRdPorts x DataWidth per-channel read data
//   rd_valid_o  out  NumRdPorts             per-channel response pulse
// -----------------------------------------------------------------------------
module hwpe_buffer_mp #(
    parameter int unsigned  NumWords   = 128,
    parameter int unsigned  DataWidth  = 32,
    parameter int unsigned  NumRdPorts = 2,
    localparam int unsigned AddrWidth  = $clog2(NumWords),
    localparam int unsigned NumBytes   = DataWidth / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  clear_i,
    input  logic                                  wr_req_i,
    input  logic [AddrWidth-1:0]                  wr_addr_i,
    input  logic [DataWidth-1:0]                  wr_data_i,
    input  logic [NumBytes-1:0]                   wr_be_i,
    input  logic [NumRdPorts-1:0]                 rd_req_i,
    input  logic [NumRdPorts-1:0][AddrWidth-1:0]  rd_addr_i,
    output logic [NumRdPorts-1:0][DataWidth-1:0]  rd_data_o,
    output logic [NumRdPorts-1:0]                 rd_valid_o
);

    // One extra bit keeps the range compare exact when NumWords is a power of two.
    localparam logic [AddrWidth:0] NumWordsExt = (AddrWidth + 1)'(NumWords);

    logic [DataWidth-1:0]                 mem_r [NumWords];
    logic [NumRdPorts-1:0][AddrWidth-1:0] r_addr_r;
    logic [NumRdPorts-1:0]                rd_valid_r;
    logic [DataWidth-1:0]                 wr_mask_s;
    logic                                 wr_en_s;

    // Returns 1 when the address refers to an existing storage word.
    function automatic logic addr_ok(input logic [AddrWidth-1:0] addr);
        return ({1'b0, addr} < NumWordsExt);
    endfunction

`ifdef HWPE_BUFFER_MP_BE_EN
    // Expands the byte enables into a bit mask over the data word.
    function automatic logic [DataWidth-1:0] be_to_mask(input logic [NumBytes-1:0] be);
        logic [DataWidth-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < NumBytes; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

    assign wr_mask_s = be_to_mask(wr_be_i);
`else
    // The byte enables stay on the port for interface compatibility only.
    logic unused_be_s;
    assign unused_be_s = ^wr_be_i;
    assign wr_mask_s   = '1;
`endif

    assign wr_en_s = wr_req_i & addr_ok(wr_addr_i);

    // Storage words: reset/clear to zero, masked merge on an in-range write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_r <= '{default: '0};
        end else if (clear_i) begin
            mem_r <= '{default: '0};
        end else if (wr_en_s) begin
            mem_r[wr_addr_i] <= (mem_r[wr_addr_i] & ~wr_mask_s) | (wr_data_i & wr_mask_s);
        end
    end

    // Per-channel held read address and the valid pulse that follows a request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_r   <= '0;
            rd_valid_r <= '0;
        end else if (clear_i) begin
            r_addr_r   <= '0;
            rd_valid_r <= '0;
        end else begin
            rd_valid_r <= rd_req_i;
            for (int unsigned k = 0; k < NumRdPorts; k++) begin
                if (rd_req_i[k]) begin
                    r_addr_r[k] <= rd_addr_i[k];
                end
            end
        end
    end

    // The lookup is combinational from the held address so later writes show through.
    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < NumRdPorts; k++) begin
            if (addr_ok(r_addr_r[k])) begin
                rd_data_o[k] = mem_r[r_addr_r[k]];
            end else begin
                rd_data_o[k] = '0;
            end
        end
    end

    assign rd_valid_o = rd_valid_r;

endmodule

// File: tb/tb_hwpe_buffer_mp.sv
// -----------------------------------------------------------------------------
// Testbench for hwpe_buffer_mp (NumWords=100 so out-of-range addresses exist).
// A behavioural memory model produces expected read data when a read is
// driven. That data is queued per channel and compared when rd_valid_o fires.
// -----------------------------------------------------------------------------
module tb_hwpe_buffer_mp;

    localparam int NW = 100;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NP = 2;

    logic                    clk_i;
    logic                    rst_ni;
    logic                    clear_i;
    logic                    wr_req_i;
    logic [AW-1:0]           wr_addr_i;
    logic [DW-1:0]           wr_data_i;
    logic [3:0]              wr_be_i;
    logic [NP-1:0]           rd_req_i;
    logic [NP-1:0][AW-1:0]   rd_addr_i;
    logic [NP-1:0][DW-1:0]   rd_data_o;
    logic [NP-1:0]           rd_valid_o;

    hwpe_buffer_mp #(
        .NumWords   (NW),
        .DataWidth  (DW),
        .NumRdPorts (NP)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .wr_req_i   (wr_req_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .wr_be_i    (wr_be_i),
        .rd_req_i   (rd_req_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [128];
    logic [AW-1:0] held_a [NP];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    task automatic model_zero();
        for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
        for (int k = 0; k < NP; k++) held_a[k] = 7'd0;
    endtask

    // Drives one cycle, updates the model and queues, then waits the edge (+1).
    task automatic do_cycle(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [3:0] be, input logic [1:0] req,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic clr);
        clear_i      = clr;
        wr_req_i     = wr;
        wr_addr_i    = wa;
        wr_data_i    = wd;
        wr_be_i      = be;
        rd_req_i     = req;
        rd_addr_i[0] = a0;
        rd_addr_i[1] = a1;
        if (clr) begin
            model_zero();
        end else begin
            if (wr && (int'(wa) < NW)) begin
`ifdef HWPE_BUFFER_MP_BE_EN
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[wa][b*8 +: 8] = wd[b*8 +: 8];
`else
                model_mem[wa] = wd;
`endif
            end
            if (req[0]) begin q0.push_back(model_mem[a0]); held_a[0] = a0; end
            if (req[1]) begin q1.push_back(model_mem[a1]); held_a[1] = a1; end
        end
        @(posedge clk_i);
        #1;
        clear_i  = 1'b0;
        wr_req_i = 1'b0;
        rd_req_i = 2'b00;
    endtask

    task automatic test_reset();
        logic [DW-1:0] exp_d;
        rst_ni    = 1'b0;
        clear_i   = 1'b0;
        wr_req_i  = 1'b0;
        wr_addr_i = 7'd0;
        wr_data_i = 32'h0;
        wr_be_i   = 4'h0;
        rd_req_i  = 2'b11;
        rd_addr_i = '0;
        model_zero();
        repeat (3) @(posedge clk_i);
        #1;
        exp_d = 32'h0;
        for (int k = 0; k < NP; k++) begin
            n_cmp++;
            if (rd_valid_o[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid ch%0d: got %b want 0", k, rd_valid_o[k]);
            end
            n_cmp++;
            if (rd_data_o[k] !== exp_d) begin
                n_err++;
                $display("FAIL reset_data ch%0d: got %h want %h", k, rd_data_o[k], exp_d);
            end
        end
        rd_req_i = 2'b00;
        rst_ni   = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_read_after_reset();
        logic [DW-1:0] exp_d;
        do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b01, 7'd5, 7'd0, 1'b0);
        exp_d = q0.pop_front();
        n_cmp++;
        if (rd_valid_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL first_read_valid: got %b want 1", rd_valid_o[0]);
        end
        n_cmp++;
        if (rd_data_o[0] !== 32'h0000_0000 || exp_d !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL first_read_data: got %h want 00000000", rd_data_o[0]);
        end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] exp_d;
        logic [DW-1:0] lit;
`ifdef HWPE_BUFFER_MP_BE_EN
        lit = 32'hDEAD_3344;
`else
        lit = 32'h1122_3344;
`endif
        do_cycle(1'b1, 7'd3, 32'hDEAD_BEEF, 4'hF, 2'b00, 7'd0, 7'd0, 1'b0);
        do_cycle(1'b1, 7'd3, 32'h1122_3344, 4'h3, 2'b00, 7'd0, 7'd0, 1'b0);
        do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b01, 7'd3, 7'd0, 1'b0);
        exp_d = q0.pop_front();
        n_cmp++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== exp_d) begin
            n_err++;
            $display("FAIL byte_enable: got v=%b %h want v=1 %h", rd_valid_o[0], rd_data_o[0], exp_d);
        end
        n_cmp++;
        if (rd_data_o[0] !== lit) begin
            n_err++;
            $display("FAIL byte_enable_lit: got %h want %h", rd_data_o[0], lit);
        end
    endtask

    task automatic test_write_first();
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        do_cycle(1'b1, 7'd7, 32'hA5A5_A5A5, 4'hF, 2'b11, 7'd7, 7'd7, 1'b0);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        n_cmp++;
        if (rd_valid_o !== 2'b11) begin
            n_err++;
            $display("FAIL write_first_valid: got %b want 11", rd_valid_o);
        end
        n_cmp++;
        if (rd_data_o[0] !== e0 || rd_data_o[0] !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL write_first_ch0: got %h want a5a5a5a5", rd_data_o[0]);
        end
        n_cmp++;
        if (rd_data_o[1] !== e1 || rd_data_o[1] !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL write_first_ch1: got %h want a5a5a5a5", rd_data_o[1]);
        end
    endtask

    task automatic test_held_address();
        logic [DW-1:0] e1;
        do_cycle(1'b1, 7'd9, 32'h0000_0042, 4'hF, 2'b00, 7'd0, 7'd0, 1'b0);
        do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b10, 7'd0, 7'd9, 1'b0);
        e1 = q1.pop_front();
        n_cmp++;
        if (rd_valid_o[1] !== 1'b1 || rd_data_o[1] !== e1 || e1 !== 32'h42) begin
            n_err++;
            $display("FAIL held_first: got v=%b %h want v=1 00000042", rd_valid_o[1], rd_data_o[1]);
        end
        do_cycle(1'b1, 7'd9, 32'h0000_0099, 4'hF, 2'b00, 7'd0, 7'd0, 1'b0);
        n_cmp++;
        if (rd_valid_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL held_valid: got %b want 0", rd_valid_o[1]);
        end
        n_cmp++;
        if (rd_data_o[1] !== 32'h0000_0099) begin
            n_err++;
            $display("FAIL held_update: got %h want 00000099", rd_data_o[1]);
        end
    endtask

    task automatic test_clear();
        logic [DW-1:0] e0;
        do_cycle(1'b1, 7'd0, 32'h0000_0077, 4'hF, 2'b01, 7'd0, 7'd0, 1'b0);
        e0 = q0.pop_front();
        n_cmp++;
        if (rd_data_o[0] !== e0) begin
            n_err++;
            $display("FAIL pre_clear: got %h want %h", rd_data_o[0], e0);
        end
        do_cycle(1'b1, 7'd0, 32'hFFFF_FFFF, 4'hF, 2'b11, 7'd0, 7'd7, 1'b1);
        n_cmp++;
        if (rd_valid_o !== 2'b00) begin
            n_err++;
            $display("FAIL clear_valid: got %b want 00", rd_valid_o);
        end
        do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'd0, 7'd7, 1'b0);
        e0 = q0.pop_front();
        n_cmp++;
        if (rd_data_o[0] !== e0 || e0 !== 32'h0) begin
            n_err++;
            $display("FAIL clear_addr0: got %h want 00000000", rd_data_o[0]);
        end
        e0 = q1.pop_front();
        n_cmp++;
        if (rd_data_o[1] !== e0 || e0 !== 32'h0) begin
            n_err++;
            $display("FAIL clear_addr7: got %h want 00000000", rd_data_o[1]);
        end
    endtask

    task automatic test_out_of_range();
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        for (int a = 0; a < NW; a++)
            do_cycle(1'b1, 7'(a), 32'hC000_0000 | 32'(a), 4'hF, 2'b00, 7'd0, 7'd0, 1'b0);
        do_cycle(1'b1, 7'd120, 32'h1234_5678, 4'hF, 2'b00, 7'd0, 7'd0, 1'b0);
        do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'd120, 7'd127, 1'b0);
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        n_cmp++;
        if (rd_valid_o !== 2'b11 || rd_data_o[0] !== e0 || e0 !== 32'h0) begin
            n_err++;
            $display("FAIL oor_read120: got v=%b %h want v=11 00000000", rd_valid_o, rd_data_o[0]);
        end
        n_cmp++;
        if (rd_data_o[1] !== e1 || e1 !== 32'h0) begin
            n_err++;
            $display("FAIL oor_read127: got %h want 00000000", rd_data_o[1]);
        end
        for (int a = 0; a < NW; a += 2) begin
            do_cycle(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'(a), 7'(a + 1), 1'b0);
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            n_cmp++;
            if (rd_data_o[0] !== e0 || rd_data_o[1] !== e1) begin
                n_err++;
                $display("FAIL oor_intact @%0d: got %h %h want %h %h", a, rd_data_o[0], rd_data_o[1], e0, e1);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e0;
        do_cycle(1'b1, 7'd1, 32'h0000_0055, 4'hF, 2'b01, 7'd1, 7'd0, 1'b0);
        e0 = q0.pop_front();
        n_cmp++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== e0) begin
            n_err++;
            $display("FAIL mid_pre: got v=%b %h want v=1 %h", rd_valid_o[0], rd_data_o[0], e0);
        end
        rd_req_i = 2'b11;
        rst_ni   = 1'b0;
        #1;
        model_zero();
        q0.delete();
        q1.delete();
        n_cmp++;
        if (rd_valid_o !== 2'b00 || rd_data_o !== '0) begin
            n_err++;
            $display("FAIL mid_async: got v=%b d=%h want 00 / 0", rd_valid_o, rd_data_o);
        end
        @(posedge clk_i);
        #1;
        rd_req_i = 2'b00;
        rst_ni   = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (rd_valid_o !== 2'b00) begin
            n_err++;
            $display("FAIL mid_no_pulse: got %b want 00", rd_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic          wr;
        logic          clr;
        logic [1:0]    req;
        logic [AW-1:0] wa;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] exp_d;
        logic [DW-1:0] got_d;
        for (int i = 0; i < 300; i++) begin
            wr  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 29) == 0);
            req = 2'($urandom_range(0, 3));
            wa  = 7'($urandom_range(0, 127));
            a0  = ($urandom_range(0, 1) == 1) ? wa : 7'($urandom_range(0, 127));
            a1  = 7'($urandom_range(0, 127));
            do_cycle(wr, wa, $urandom, 4'($urandom_range(0, 15)), req, a0, a1, clr);
            for (int k = 0; k < NP; k++) begin
                n_cmp++;
                if (rd_valid_o[k] !== (req[k] & ~clr)) begin
                    n_err++;
                    $display("FAIL b2b_valid i=%0d ch%0d: got %b want %b", i, k, rd_valid_o[k], req[k] & ~clr);
                end
                got_d = rd_data_o[k];
                if (req[k] && !clr) exp_d = (k == 0) ? q0.pop_front() : q1.pop_front();
                else                exp_d = model_mem[held_a[k]];
                n_cmp++;
                if (got_d !== exp_d) begin
                    n_err++;
                    $display("FAIL b2b_data i=%0d ch%0d: got %h want %h", i, k, got_d, exp_d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_byte_enable();
        test_write_first();
        test_held_address();
        test_clear();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_buffer_mp.md
HWPE_BUFFER_MP -- requirements
Module: hwpe_buffer_mp

Interface
REQ-001 The block SHALL have parameter NumWords, default 128: storage depth in words, minimum 2.
REQ-002 The block SHALL have parameter DataWidth, default 32: word width in bits, a multiple of 8.
REQ-003 The block SHALL have parameter NumRdPorts, default 2: number of independent read channels, minimum 1.
REQ-004 The block SHALL derive AddrWidth = $clog2(NumWords) and NumBytes = DataWidth/8.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port clear_i, input, 1 bit: synchronous clear of storage and read state.
REQ-008 The block SHALL have port wr_req_i, input, 1 bit: write request.
REQ-009 The block SHALL have port wr_addr_i, input, AddrWidth bits: write word address.
REQ-010 The block SHALL have port wr_data_i, input, DataWidth bits: write data.
REQ-011 The block SHALL have port wr_be_i, input, NumBytes bits: write byte enables.
REQ-012 The block SHALL have port rd_req_i, input, NumRdPorts bits: per-channel read request.
REQ-013 The block SHALL have port rd_addr_i, input, NumRdPorts x AddrWidth bits: per-channel read address.
REQ-014 The block SHALL have port rd_data_o, output, NumRdPorts x DataWidth bits: per-channel read data.
REQ-015 The block SHALL have port rd_valid_o, output, NumRdPorts bits: per-channel one-cycle pulse, high when rd_data_o carries the response to a request.

Function
REQ-016 Storage SHALL be NumWords flip-flop words; all channels SHALL be served every cycle with no arbitration and no stalls.
REQ-017 A write with wr_req_i=1 SHALL update the enabled bytes of word wr_addr_i at the clock edge; disabled bytes keep their value.
REQ-018 Each channel k SHALL hold a registered address r_addr_q[k], loaded with rd_addr_i[k] on an edge where rd_req_i[k]=1 and held otherwise.
REQ-019 rd_data_o[k] SHALL equal mem_q[r_addr_q[k]] combinationally: read latency is exactly 1 cycle, and a write to a held address becomes visible on rd_data_o the cycle after the write.
REQ-020 rd_valid_o[k] SHALL be 1 in the cycle after a cycle with rd_req_i[k]=1, otherwise 0.
REQ-021 A read and a write to the same address in the same cycle SHALL return the newly written data in the response cycle (write-first).
REQ-022 Multiple channels reading the same address in the same cycle SHALL all return identical data.
REQ-023 Any address >= NumWords SHALL be ignored for writes; a read of such an address SHALL return all zeros with rd_valid_o still asserted.
REQ-024 clear_i=1 SHALL zero all storage words and all r_addr_q and rd_valid_o at the next edge, and SHALL take priority over a simultaneous write and over simultaneous reads.

Reset
REQ-025 rst_ni low SHALL asynchronously zero all storage words, every r_addr_q and every rd_valid_o, so rd_data_o reads 0 throughout reset.
REQ-026 Reset asserted mid-operation SHALL discard the pending responses; no rd_valid_o pulse SHALL follow reset deassertion without a new request.

Configuration
REQ-027 With macro HWPE_BUFFER_MP_BE_EN defined, wr_be_i SHALL gate bytes as in REQ-017.
REQ-028 Without HWPE_BUFFER_MP_BE_EN, the block SHALL keep port wr_be_i but ignore it, and every write SHALL update the full word.

Verification
REQ-029 Reset, then read channel 0 at address 5 -> the next cycle shows rd_valid_o[0]=1 and rd_data_o[0]=0x00000000.
REQ-030 Write 0xDEADBEEF to address 3 with be=0xF, then write 0x11223344 with be=0x3 -> a read returns 0xDEAD3344 (0x11223344 without the macro).
REQ-031 In one cycle, write 0xA5A5A5A5 to address 7 while channels 0 and 1 read address 7 -> the next cycle shows both channels at 0xA5A5A5A5 with valid=1.
REQ-032 Channel 1 reads address 9 (0x00000042), then idles while 0x00000099 is written to address 9 -> rd_valid_o[1]=0 and rd_data_o[1] changes from 0x42 to 0x99 one cycle after the write.
REQ-033 Assert clear_i together with a write of 0xFFFFFFFF to address 0 -> a read of address 0 returns 0, and rd_valid_o is 0 in the cycle after the clear.
REQ-034 With NumWords=100, write 0x12345678 to address 120 and read it -> the read returns 0 and addresses 0-99 are unchanged.
